// File: rtl/conv_param_loader.sv
// conv_param_loader: streams parameter words into conv1d bank memory, reads them back and checks an XOR checksum.
module conv_param_loader #(
  parameter int NUM_FILTERS = 8,
  parameter int COLUMN_LEN = 2,
  parameter int BW = 8,
  localparam int ADDR_BW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int VECTOR_BW = COLUMN_LEN * BW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [VECTOR_BW-1:0] cfg_data_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  output logic                 mem_wr_en_o,
  output logic                 mem_rd_en_o,
  output logic [1:0]           mem_bank_o,
  output logic [ADDR_BW-1:0]   mem_addr_o,
  output logic [VECTOR_BW-1:0] mem_wr_data_o,
  input  logic [VECTOR_BW-1:0] mem_rd_data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, VERIFY = 3'd2, CHECK = 3'd3, DONE = 3'd4;
  localparam logic [ADDR_BW-1:0] LAST_ADDR = ADDR_BW'(NUM_FILTERS - 1);
  logic [2:0] state_q, state_d;
  logic [1:0] bank_q, bank_d;
  logic [ADDR_BW-1:0] addr_q, addr_d;
  logic [VECTOR_BW-1:0] wr_sum_q, wr_sum_d, rd_sum_q, rd_sum_d, rd_fold;
  logic rd_pend_q, err_q, err_d, hs, adv, last, strobe;
  always_comb begin
    hs = state_q == LOAD && cfg_valid_i;
    adv = hs || state_q == VERIFY;
    last = bank_q == 2'd3 && addr_q == LAST_ADDR;
    // read data lands one cycle after its strobe, so the final word is folded in CHECK
    rd_fold = rd_pend_q ? rd_sum_q ^ mem_rd_data_i : rd_sum_q;
    state_d = state_q;
    bank_d = bank_q;
    addr_d = addr_q;
    wr_sum_d = hs ? wr_sum_q ^ cfg_data_i : wr_sum_q;
    rd_sum_d = rd_fold;
    err_d = err_q;
    if (adv) begin
      addr_d = addr_q == LAST_ADDR ? '0 : addr_q + 1'b1;
      bank_d = addr_q == LAST_ADDR ? bank_q + 2'd1 : bank_q;
    end
    if (state_q == IDLE && start_i) begin
      state_d = LOAD;
      bank_d = '0;
      addr_d = '0;
      wr_sum_d = '0;
      rd_sum_d = '0;
      err_d = 1'b0;
    end
    if (adv && last) state_d = state_q == LOAD ? VERIFY : CHECK;
    if (state_q == CHECK) begin
      err_d = wr_sum_q != rd_fold;
      state_d = DONE;
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      bank_q <= '0;
      addr_q <= '0;
      wr_sum_q <= '0;
      rd_sum_q <= '0;
      rd_pend_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q <= bank_d;
      addr_q <= addr_d;
      wr_sum_q <= wr_sum_d;
      rd_sum_q <= rd_sum_d;
      rd_pend_q <= mem_rd_en_o;
      err_q <= err_d;
    end
  end
  assign strobe = hs || state_q == VERIFY;
  assign cfg_ready_o = state_q == LOAD;
  assign mem_wr_en_o = hs;
  assign mem_rd_en_o = state_q == VERIFY;
  assign mem_bank_o = strobe ? bank_q : '0;
  assign mem_addr_o = strobe ? addr_q : '0;
  assign mem_wr_data_o = hs ? cfg_data_i : '0;
  assign busy_o = state_q == LOAD || state_q == VERIFY || state_q == CHECK;
  assign done_o = state_q == DONE;
  assign err_o = err_q;
endmodule

// File: tb/tb_conv_param_loader.sv
// tb_conv_param_loader: directed checks of the loader against 1-cycle-latency memory models (8 and 5 filters).
module tb_conv_param_loader;
  logic clk, rst, start, cfg_valid, cfg_ready, wr_en, rd_en, busy, done, err;
  logic [15:0] cfg_data, wr_data, rd_data;
  logic [1:0] bank;
  logic [2:0] addr;
  logic start_b, valid_b, ready_b, wr_en_b, rd_en_b, busy_b, done_b, err_b;
  logic [15:0] data_b, wr_data_b, rd_data_b;
  logic [1:0] bank_b;
  logic [2:0] addr_b;
  logic [15:0] mem [0:31];
  logic [15:0] mem_b [0:19];
  logic flip;
  int n_chk, n_fail, cyc, wr_cnt, rd_cnt, ord_bad, done_cnt, done_cyc, d0;
  int wb_cnt, rb_cnt, bad_b, done_b_cnt, done_b_cyc, eb, ea, rb, ra;
  bit err_at_done, err_b_at_done;

  conv_param_loader dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_data_i(cfg_data), .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready), .mem_wr_en_o(wr_en), .mem_rd_en_o(rd_en), .mem_bank_o(bank),
    .mem_addr_o(addr), .mem_wr_data_o(wr_data), .mem_rd_data_i(rd_data), .busy_o(busy),
    .done_o(done), .err_o(err));

  conv_param_loader #(.NUM_FILTERS(5)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .cfg_data_i(data_b), .cfg_valid_i(valid_b),
    .cfg_ready_o(ready_b), .mem_wr_en_o(wr_en_b), .mem_rd_en_o(rd_en_b), .mem_bank_o(bank_b),
    .mem_addr_o(addr_b), .mem_wr_data_o(wr_data_b), .mem_rd_data_i(rd_data_b), .busy_o(busy_b),
    .done_o(done_b), .err_o(err_b));

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (wr_en) mem[{bank, addr}] <= wr_data;
    if (rd_en) rd_data <= mem[{bank, addr}] ^ {15'd0, flip && bank == 2'd2 && addr == 3'd5};
    if (wr_en_b) mem_b[int'(bank_b) * 5 + int'(addr_b)] <= wr_data_b;
    if (rd_en_b) rd_data_b <= mem_b[int'(bank_b) * 5 + int'(addr_b)];
  end

  always @(negedge clk) begin
    if (wr_en) begin
      if ({bank, addr} != 5'(wr_cnt) || wr_data != 16'(wr_cnt)) ord_bad++;
      wr_cnt++;
    end
    if (rd_en) begin
      if ({bank, addr} != 5'(rd_cnt)) ord_bad++;
      rd_cnt++;
    end
    if (wr_en && rd_en) ord_bad++;
    if (done) begin done_cnt++; done_cyc = cyc; err_at_done = err; end
    if (wr_en_b) begin
      if (int'(bank_b) != eb || int'(addr_b) != ea || wr_data_b != 16'(wb_cnt)) bad_b++;
      wb_cnt++;
      if (ea == 4) begin ea = 0; eb++; end else ea++;
    end
    if (rd_en_b) begin
      if (int'(bank_b) != rb || int'(addr_b) != ra) bad_b++;
      rb_cnt++;
      if (ra == 4) begin ra = 0; rb++; end else ra++;
    end
    if (wr_en_b && rd_en_b) bad_b++;
    if (done_b) begin done_b_cnt++; done_b_cyc = cyc; err_b_at_done = err_b; end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_seq(input bit gap, input int p1, input int p2, output int rel, output bit err_c1);
    int t0, widx;
    bit hs;
    wr_cnt = 0; rd_cnt = 0; ord_bad = 0; d0 = done_cnt; widx = 0; hs = 0; err_c1 = 1'b1;
    @(posedge clk); #1;
    start = 1; cfg_valid = 0; cfg_data = 0; t0 = cyc;
    for (int n = 1; n < 200 && done_cnt == d0; n++) begin
      @(posedge clk); #1;
      if (hs) widx++;
      start = (n == p1 || n == p2);
      cfg_valid = gap ? (n % 2 == 0) : 1'b1;
      cfg_data = 16'(widx);
      if (n == 1) err_c1 = err;
      @(negedge clk);
      hs = cfg_valid && cfg_ready;
    end
    rel = (done_cnt == d0) ? -1 : done_cyc - t0;
    @(posedge clk); #1;
    start = 0; cfg_valid = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int rel, bad, t0, wb;
    bit e1, hs_b;
    n_chk = 0; n_fail = 0; cyc = 0; done_cnt = 0; done_b_cnt = 0; flip = 0;
    wr_cnt = 0; rd_cnt = 0; ord_bad = 0; wb_cnt = 0; rb_cnt = 0; bad_b = 0; eb = 0; ea = 0; rb = 0; ra = 0;
    rst = 1; start = 0; cfg_valid = 0; cfg_data = 0; start_b = 0; valid_b = 0; data_b = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {cfg_ready, wr_en, rd_en, bank, addr, wr_data, busy, done, err}, 0);
    check("reset_outs_b", {ready_b, wr_en_b, rd_en_b, busy_b, done_b, err_b}, 0);
    rst = 0;

    run_seq(0, 0, 0, rel, e1);
    check("t1_order", ord_bad, 0);
    check("t1_writes", wr_cnt, 32);
    check("t1_reads", rd_cnt, 32);
    check("t1_done_cycle", rel, 66);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_err", err_at_done, 0);
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] != 16'(i)) bad++;
    check("t1_mem_contents", bad, 0);

    flip = 1;
    run_seq(0, 0, 0, rel, e1);
    check("t2_err_at_done", err_at_done, 1);
    check("t2_err_sticky", err, 1);
    flip = 0;
    run_seq(0, 0, 0, rel, e1);
    check("t2_err_cleared", e1, 0);
    check("t2_clean_err", err_at_done, 0);

    run_seq(1, 0, 0, rel, e1);
    check("t3_order", ord_bad, 0);
    check("t3_writes", wr_cnt, 32);
    check("t3_done_cycle", rel, 98);
    check("t3_err", err_at_done, 0);

    run_seq(0, 5, 40, rel, e1);
    check("t4_done_cycle", rel, 66);
    check("t4_done_pulses", done_cnt - d0, 1);
    check("t4_err", err_at_done, 0);

    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0; cfg_valid = 1; cfg_data = 0;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      cfg_data = 16'(k);
    end
    check("t5_pre_rst_pos", {wr_en, bank, addr}, {1'b1, 5'd13});
    #2 rst = 1;
    #1;
    check("t5_rst_outs", {cfg_ready, wr_en, rd_en, bank, addr, wr_data, busy, done, err}, 0);
    cfg_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    run_seq(0, 0, 0, rel, e1);
    check("t5_order", ord_bad, 0);
    check("t5_writes", wr_cnt, 32);
    check("t5_done_cycle", rel, 66);
    check("t5_err", err_at_done, 0);

    @(posedge clk); #1;
    start_b = 1; t0 = cyc; wb = 0; hs_b = 0;
    for (int n = 1; n < 100 && done_b_cnt == 0; n++) begin
      @(posedge clk); #1;
      if (hs_b) wb++;
      start_b = 0; valid_b = 1; data_b = 16'(wb);
      @(negedge clk);
      hs_b = valid_b && ready_b;
    end
    valid_b = 0;
    check("t6_order", bad_b, 0);
    check("t6_writes", wb_cnt, 20);
    check("t6_reads", rb_cnt, 20);
    check("t6_done_cycle", done_b_cnt == 0 ? -1 : done_b_cyc - t0, 42);
    check("t6_err", err_b_at_done, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) if (mem_b[i] != 16'(i)) bad++;
    check("t6_mem_contents", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
